// File: rtl/plusarg_watchdog.sv
// plusarg_watchdog: cycle-budget watchdog (IDLE/RUN/EXPIRED) with registered outputs.
// Define PLUSARG_WATCHDOG_FATAL_EN (without SYNTHESIS) to end simulation on expiry.
module plusarg_watchdog #(
    parameter int WIDTH = 32,
    parameter     NAME  = "watchdog"
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      limit,
    input  logic             enable,
    input  logic             kick,
    input  logic             clear,
    output logic             running,
    output logic             timeout,
    output logic             expired,
    output logic [WIDTH-1:0] count
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] lim_q, lim_d, count_d, lim_in;
    logic             at_end;
    // Budgets wider than the counter saturate rather than truncate
    assign lim_in = (limit >> WIDTH) != 32'd0 ? '1 : limit[WIDTH-1:0];
    assign at_end = count == lim_q - WIDTH'(1);
    always_comb begin
        state_d = state;
        count_d = count;
        lim_d   = lim_q;
        if (state == IDLE) begin
            count_d = '0;
            if (enable && limit != 32'd0) begin
                state_d = RUN;
                lim_d   = lim_in;
            end
        end else if (state == RUN) begin
            if (!enable) begin
                state_d = IDLE;
                count_d = '0;
            end else if (kick) begin
                count_d = '0;
            end else if (at_end) begin
                state_d = EXPIRED;
                count_d = lim_q;
            end else begin
                count_d = count + WIDTH'(1);
            end
        end else if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            lim_q   <= '0;
            running <= 1'b0;
            timeout <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            lim_q   <= lim_d;
            running <= state_d == RUN;
            timeout <= state_d == EXPIRED;
            expired <= state_d == EXPIRED && state != EXPIRED;
        end
    end
`ifdef PLUSARG_WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset_n && state == RUN && state_d == EXPIRED) begin
            $display("%s: timeout after %0d cycles", NAME, lim_q);
            $fatal(1);
        end
    end
`endif
`endif
endmodule

// File: tb/tb_plusarg_watchdog.sv
// tb_plusarg_watchdog: directed and random stimulus against a cycle-budget model,
// driving a 32-bit and an 8-bit (saturating) instance in parallel.
module tb_plusarg_watchdog;
    logic        clock, reset_n, enable, kick, clear, cmp_en;
    logic [31:0] limit, c32;
    logic [7:0]  c8;
    logic        r32, t32, e32, r8, t8, e8;
    int          tests, fails;
    bit          m_run[2], m_exp[2], m_new[2];
    int unsigned m_cnt[2], m_bud[2];

    plusarg_watchdog #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .limit(limit), .enable(enable), .kick(kick),
        .clear(clear), .running(r32), .timeout(t32), .expired(e32), .count(c32));
    plusarg_watchdog #(.WIDTH(8), .NAME("wd8")) dut8 (
        .clock(clock), .reset_n(reset_n), .limit(limit), .enable(enable), .kick(kick),
        .clear(clear), .running(r8), .timeout(t8), .expired(e8), .count(c8));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int unsigned budget(input int i, input logic [31:0] l);
        return (i == 1 && l > 32'd255) ? 255 : l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_exp[i] = 0; m_new[i] = 0; m_cnt[i] = 0; m_bud[i] = 0;
        end
    endtask

    // Count = cycles since the last restart; expiry when that reaches the latched budget
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_new[i] = 0;
            if (m_exp[i]) begin
                if (clear) begin m_exp[i] = 0; m_cnt[i] = 0; end
            end else if (m_run[i]) begin
                if (!enable) begin m_run[i] = 0; m_cnt[i] = 0; end
                else if (kick) m_cnt[i] = 0;
                else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == m_bud[i]) begin m_run[i] = 0; m_exp[i] = 1; m_new[i] = 1; end
                end
            end else if (enable && limit != 0) begin
                m_run[i] = 1; m_cnt[i] = 0; m_bud[i] = budget(i, limit);
            end
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("run32", r32, m_run[0]);
            chk("tmo32", t32, m_exp[0]);
            chk("exp32", e32, m_new[0]);
            chk("cnt32", c32, m_cnt[0]);
            chk("run8", r8, m_run[1]);
            chk("tmo8", t8, m_exp[1]);
            chk("exp8", e8, m_new[1]);
            chk("cnt8", {24'd0, c8}, m_cnt[1]);
            chk("excl32", r32 & t32, 0);
        end
    end

    task automatic step(input bit en, input bit kk, input bit cl, input logic [31:0] lim);
        enable = en; kick = kk; clear = cl; limit = lim;
        @(posedge clock);
        model_step();
        #2;
    endtask

    task automatic areset();
        #1 reset_n = 1'b0;
        #1 model_reset();
        chk("ar_run32", r32, 0); chk("ar_tmo32", t32, 0); chk("ar_exp32", e32, 0); chk("ar_cnt32", c32, 0);
        chk("ar_run8", r8, 0); chk("ar_tmo8", t8, 0); chk("ar_exp8", e8, 0); chk("ar_cnt8", {24'd0, c8}, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; cmp_en = 0;
        reset_n = 1'b0; enable = 0; kick = 0; clear = 0; limit = 0;
        model_reset();
        #12 reset_n = 1'b1;
        chk("rst_run", r32, 0); chk("rst_tmo", t32, 0); chk("rst_cnt", c32, 0);
        cmp_en = 1;
        // five-cycle budget, no kick
        step(1, 0, 0, 5);
        chk("e0_run", r32, 1); chk("e0_cnt", c32, 0);
        for (int e = 1; e < 5; e++) step(1, 0, 0, 5);
        chk("e4_cnt", c32, 4); chk("e4_tmo", t32, 0);
        step(1, 0, 0, 5);
        chk("e5_tmo", t32, 1); chk("e5_exp", e32, 1); chk("e5_cnt", c32, 5);
        step(1, 1, 0, 5);
        chk("e6_exp", e32, 0); chk("e6_tmo", t32, 1); chk("e6_cnt", c32, 5);
        step(0, 0, 1, 5);
        chk("clr_tmo", t32, 0); chk("clr_cnt", c32, 0);
        // kicks on E2 and E5
        for (int e = 0; e < 10; e++) begin
            step(1, e == 2 || e == 5, 0, 4);
            if (e == 2) chk("k_e2_cnt", c32, 0);
            if (e == 8) chk("k_e8_tmo", t32, 0);
            if (e == 9) begin chk("k_e9_tmo", t32, 1); chk("k_e9_cnt", c32, 4); end
        end
        step(0, 0, 1, 4);
        // kick on the terminal edge
        for (int e = 0; e < 9; e++) begin
            step(1, e == 4, 0, 4);
            if (e == 4) begin chk("term_tmo", t32, 0); chk("term_cnt", c32, 0); end
            if (e == 8) chk("term_e8_tmo", t32, 1);
        end
        step(0, 0, 0, 4);
        chk("exp_hold_en0", t32, 1);
        step(0, 0, 1, 0);
        // limit 0 keeps the block idle
        for (int e = 0; e < 100; e++) step(1, 0, 0, 0);
        chk("lim0_run", r32, 0); chk("lim0_cnt", c32, 0); chk("lim0_tmo", t32, 0);
        // limit change during RUN is ignored
        for (int e = 0; e < 11; e++) begin
            step(1, 0, 0, e < 2 ? 10 : 3);
            if (e == 9) chk("chg_e9_tmo", t32, 0);
            if (e == 10) begin chk("chg_e10_tmo", t32, 1); chk("chg_e10_cnt", c32, 10); end
        end
        step(1, 0, 1, 3);
        chk("chg_clr_run", r32, 0);
        for (int e = 0; e < 4; e++) begin
            step(1, 0, 0, 3);
            if (e == 2) chk("re_e2_tmo", t32, 0);
            if (e == 3) begin chk("re_e3_tmo", t32, 1); chk("re_e3_cnt", c32, 3); end
        end
        step(0, 0, 1, 0);
        // budget of one
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("one_tmo", t32, 1); chk("one_cnt", c32, 1);
        step(0, 0, 1, 0);
        // async reset mid-RUN and in EXPIRED
        for (int e = 0; e < 8; e++) step(1, 0, 0, 20);
        chk("ar_pre_cnt", c32, 7);
        areset();
        for (int e = 0; e < 3; e++) step(1, 0, 0, 2);
        chk("ar_pre_tmo", t32, 1);
        areset();
        // saturation on the 8-bit instance
        step(1, 0, 0, 32'h1_0000);
        for (int e = 0; e < 254; e++) step(1, 0, 0, 32'h1_0000);
        chk("sat_e254_tmo", t8, 0); chk("sat_e254_cnt", {24'd0, c8}, 254);
        step(1, 0, 0, 32'h1_0000);
        chk("sat_e255_tmo", t8, 1); chk("sat_e255_cnt", {24'd0, c8}, 255);
        areset();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned sel;
            logic [31:0] lim;
            sel = $urandom_range(0, 99);
            lim = sel < 10 ? 32'd0 : sel < 70 ? 32'($urandom_range(1, 12)) :
                  sel < 95 ? 32'($urandom_range(13, 40)) : 32'($urandom_range(256, 384));
            step($urandom_range(0, 99) < 93, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) == 0, lim);
            if ($urandom_range(0, 299) == 0) areset();
        end
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/plusarg_watchdog.md
PLUSARG_WATCHDOG -- requirements
Module: plusarg_watchdog

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the internal counter and of the count output; legal range 8..32.
REQ-002 SHALL have parameter NAME, default "watchdog": string printed in the fatal message (REQ-027).
REQ-003 SHALL have port clock  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port limit  input  32: cycle budget, normally driven by the out port of a plusarg_reader; 0 means disabled.
REQ-006 SHALL have port enable  input  1: arms the watchdog when high.
REQ-007 SHALL have port kick  input  1: progress indication; restarts the count.
REQ-008 SHALL have port clear  input  1: acknowledges and leaves EXPIRED.
REQ-009 SHALL have port running  output  1: high in state RUN.
REQ-010 SHALL have port timeout  output  1: sticky, high in state EXPIRED.
REQ-011 SHALL have port expired  output  1: one-cycle pulse on entry to EXPIRED.
REQ-012 SHALL have port count  output  WIDTH: cycles since the last restart, zero-extended.

Function
REQ-013 SHALL implement three states: IDLE, RUN and EXPIRED; all outputs SHALL be registered.
REQ-014 IDLE -> RUN on an edge with enable=1 and limit!=0; on that edge, lim_q SHALL latch limit[WIDTH-1:0], saturated to all-ones if limit[31:WIDTH] is nonzero, and count SHALL be set to 0.
REQ-015 IDLE SHALL hold count at 0; enable=1 with limit=0 SHALL keep the block in IDLE.
REQ-016 Changes to limit while in RUN SHALL be ignored until the next entry to RUN.
REQ-017 In RUN, on each edge: if enable=0, go to IDLE and clear count; else if kick=1, set count to 0; else if count==lim_q-1, go to EXPIRED; else increment count by 1.
REQ-018 Priority in RUN SHALL be enable=0 > kick > expiry; a kick on the terminal edge SHALL prevent expiry.
REQ-019 With no kick, timeout SHALL rise exactly lim_q clock edges after the RUN-entry edge; lim_q=1 SHALL therefore expire on the first edge after entry.
REQ-020 On entry to EXPIRED, count SHALL be set to lim_q and held; expired SHALL be high for exactly that one cycle.
REQ-021 EXPIRED SHALL ignore kick and enable; clear=1 SHALL move it to IDLE and zero count. clear in IDLE or RUN SHALL have no effect.
REQ-022 The counter SHALL never wrap: the expiry check precedes increment, and count <= lim_q always holds.
REQ-023 running, timeout and expired SHALL be mutually consistent: running and timeout are never both high.

Reset
REQ-024 Asserting reset_n low SHALL immediately, without waiting for a clock edge, force state IDLE, count=0, lim_q=0, and running=timeout=expired=0, including when asserted mid-RUN or in EXPIRED.
REQ-025 After reset_n is released, the first IDLE -> RUN transition SHALL occur on the first edge that meets REQ-014.

Configuration
REQ-026 Macro PLUSARG_WATCHDOG_FATAL_EN SHALL select simulation termination on expiry.
REQ-027 With the macro defined and SYNTHESIS undefined, the entry to EXPIRED SHALL print "<NAME>: timeout after <lim_q> cycles" and call $fatal on the same edge.
REQ-028 Without the macro, or when SYNTHESIS is defined, the block SHALL contain no simulation tasks, and expiry SHALL be signalled only on its ports; port-level behaviour SHALL be identical in both builds.

Verification
REQ-029 limit=5, enable=1, no kick -> running=1 on edge E0, count 0,1,2,3,4, then timeout=1 and expired pulse on E5, count=5.
REQ-030 limit=4, kick on edges E2 and E5 -> count restarts to 0 after each kick; timeout rises on E9; a kick coincident with the terminal edge prevents expiry.
REQ-031 limit=0 with enable=1 for 100 cycles -> remains in IDLE with running=0, count=0 and timeout=0.
REQ-032 Change limit from 10 to 3 at E2 of RUN -> expiry still occurs on E10; after clear and re-entry, expiry occurs 3 edges after entry.
REQ-033 reset_n low asynchronously during RUN (count=7) and during EXPIRED -> all outputs 0 before the next edge; limit=0x1_0000 with WIDTH=16 -> lim_q=0xFFFF.
REQ-034 Build with PLUSARG_WATCHDOG_FATAL_EN, limit=2 -> message printed and $fatal on E2; build without it -> simulation continues with timeout held at 1.
